// File: rtl/mag_minmax_tracker_pkg.sv
// Shared definitions for the min/max tracker: FSM encoding and counter width.
package mag_minmax_tracker_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mag_minmax_tracker_cmp.sv
// Unsigned magnitude comparator: reports i_a == / > / < i_b.
module mag_minmax_tracker_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_eq,
    output logic             o_gt,
    output logic             o_lt
);

    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);
    assign o_lt = (i_a <  i_b);

endmodule

// File: rtl/mag_minmax_tracker.sv
// Framed running max/min tracker behind a valid/ready input and output.
// Optional feature macro: MINMAX_INDEX_EN adds out_max_idx/out_min_idx, the
// 0-based frame position of the first occurrence of the max/min sample.
module mag_minmax_tracker
    import mag_minmax_tracker_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_max,
    output logic [WIDTH-1:0]   out_min,
`ifdef MINMAX_INDEX_EN
    output logic [COUNT_W-1:0] out_max_idx,
    output logic [COUNT_W-1:0] out_min_idx,
`endif
    output logic [COUNT_W-1:0] out_count
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_max;
    logic [WIDTH-1:0]   r_min;
    logic [COUNT_W-1:0] r_count;
    logic               w_accept;
    logic               w_last;
    logic               w_first;
    logic               w_max_eq, w_max_gt, w_max_lt;
    logic               w_min_eq, w_min_gt, w_min_lt;

`ifdef MINMAX_INDEX_EN
    logic [COUNT_W-1:0] r_max_idx;
    logic [COUNT_W-1:0] r_min_idx;
`endif

    // Only GT of the max compare and LT of the min compare steer updates;
    // equality keeps the earliest value by simply not updating.
    logic w_unused;
    assign w_unused = &{1'b0, w_max_eq, w_max_lt, w_min_eq, w_min_gt};

    mag_minmax_tracker_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .i_a  (in_data),
        .i_b  (r_max),
        .o_eq (w_max_eq),
        .o_gt (w_max_gt),
        .o_lt (w_max_lt)
    );

    mag_minmax_tracker_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .i_a  (in_data),
        .i_b  (r_min),
        .o_eq (w_min_eq),
        .o_gt (w_min_gt),
        .o_lt (w_min_lt)
    );

    // clr suppresses the accept so an aborted cycle never touches the datapath.
    assign w_accept = in_valid & (r_state == ST_ACCUM) & ~clr;
    assign w_first  = (r_count == '0);
    assign w_last   = (r_count == COUNT_W'(FRAME_LEN - 1));

    // State register.
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; clr overrides every other transition.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (start)              w_state_nxt = ST_ACCUM;
                ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_DONE;
                ST_DONE:  if (out_ready)          w_state_nxt = ST_IDLE;
                default:                          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            ST_ACCUM: in_ready  = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Sample counter and running max/min; values persist across IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_max   <= '0;
            r_min   <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (w_first) begin
                r_max <= in_data;
                r_min <= in_data;
            end else begin
                if (w_max_gt) r_max <= in_data;
                if (w_min_lt) r_min <= in_data;
            end
        end
    end

`ifdef MINMAX_INDEX_EN
    // Frame positions of the first max/min occurrence, same update rules.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else if (!clr && r_state == ST_IDLE && start) begin
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else if (w_accept) begin
            if (w_first || w_max_gt) r_max_idx <= r_count;
            if (w_first || w_min_lt) r_min_idx <= r_count;
        end
    end

    assign out_max_idx = r_max_idx;
    assign out_min_idx = r_min_idx;
`endif

    assign out_max   = r_max;
    assign out_min   = r_min;
    assign out_count = r_count;

endmodule
